// File: rtl/switch_mcu_wb_regfile.sv
// 31x32 register file for the multi-cycle MCU core: operand read at step 0,
// prioritised four-source writeback at step 2, with retire pulse, write counter and conflict flag.
module switch_mcu_wb_regfile (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [3:0]  in_cycle_cnt,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_auipc_waddr,
  input  logic [4:0]  in_lui_waddr,
  input  logic [4:0]  in_alu_waddr,
  input  logic [4:0]  in_load_waddr,
  input  logic        in_auipc_wen,
  input  logic        in_lui_wen,
  input  logic        in_alu_wen,
  input  logic        in_load_wen,
  input  logic [31:0] in_auipc_wdata,
  input  logic [31:0] in_lui_wdata,
  input  logic [31:0] in_alu_wdata,
  input  logic [31:0] in_load_wdata,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic        out_retire,
  output logic        out_wb_conflict,
  output logic [15:0] out_wb_cnt
);

  logic [31:0] regs_r [1:31];
  logic [31:0] rs1_data_r, rs2_data_r;
  logic        retire_r, conflict_r;
  logic [15:0] wb_cnt_r;

  logic        read_step_s, wb_step_s, any_wen_s, multi_wen_s;
  logic [2:0]  wen_cnt_s;
  logic [4:0]  win_addr_s;
  logic [31:0] win_data_s;

  // x0 has no storage and reads as zero
  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (idx == 5'd0) begin
      return 32'd0;
    end else begin
      return regs_r[idx];
    end
  endfunction

  // Step decode and fixed-priority writeback source selection
  always_comb begin
    read_step_s = (in_cycle_cnt == 4'd0);
    wb_step_s   = (in_cycle_cnt == 4'd2);
    wen_cnt_s   = {2'b00, in_load_wen} + {2'b00, in_alu_wen}
                + {2'b00, in_lui_wen} + {2'b00, in_auipc_wen};
    any_wen_s   = (wen_cnt_s != 3'd0);
    multi_wen_s = (wen_cnt_s >= 3'd2);
    win_addr_s  = 5'd0;
    win_data_s  = 32'd0;
    if (in_load_wen) begin
      win_addr_s = in_load_waddr;
      win_data_s = in_load_wdata;
    end else if (in_alu_wen) begin
      win_addr_s = in_alu_waddr;
      win_data_s = in_alu_wdata;
    end else if (in_lui_wen) begin
      win_addr_s = in_lui_waddr;
      win_data_s = in_lui_wdata;
    end else if (in_auipc_wen) begin
      win_addr_s = in_auipc_waddr;
      win_data_s = in_auipc_wdata;
    end else begin
      win_addr_s = 5'd0;
      win_data_s = 32'd0;
    end
  end

  // Register array, operand latches and writeback status
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
      rs1_data_r <= 32'd0;
      rs2_data_r <= 32'd0;
      retire_r   <= 1'b0;
      conflict_r <= 1'b0;
      wb_cnt_r   <= 16'd0;
    end else begin
      retire_r <= wb_step_s && any_wen_s;
      if (read_step_s) begin
        rs1_data_r <= read_reg(in_rs1);
        rs2_data_r <= read_reg(in_rs2);
      end
      if (wb_step_s && any_wen_s) begin
        if (multi_wen_s) begin
          conflict_r <= 1'b1;
        end
        // a winner addressing x0 retires but neither writes nor counts
        if (win_addr_s != 5'd0) begin
          regs_r[win_addr_s] <= win_data_s;
          wb_cnt_r           <= wb_cnt_r + 16'd1;
        end
      end
    end
  end

  assign out_rs1_data    = rs1_data_r;
  assign out_rs2_data    = rs2_data_r;
  assign out_retire      = retire_r;
  assign out_wb_conflict = conflict_r;
  assign out_wb_cnt      = wb_cnt_r;

endmodule

// File: tb/tb_switch_mcu_wb_regfile.sv
// Self-checking bench for switch_mcu_wb_regfile: directed scenarios plus random
// traffic against an array-based reference model of the register file.
module tb_switch_mcu_wb_regfile;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic [3:0]  in_cycle_cnt;
  logic [4:0]  in_rs1, in_rs2;
  logic [4:0]  in_auipc_waddr, in_lui_waddr, in_alu_waddr, in_load_waddr;
  logic        in_auipc_wen, in_lui_wen, in_alu_wen, in_load_wen;
  logic [31:0] in_auipc_wdata, in_lui_wdata, in_alu_wdata, in_load_wdata;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic        out_retire, out_wb_conflict;
  logic [15:0] out_wb_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_regs [0:31];
  logic [31:0] m_rs1, m_rs2;
  logic        m_retire, m_conf;
  logic [15:0] m_cnt;

  switch_mcu_wb_regfile dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_cycle_cnt(in_cycle_cnt),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_auipc_waddr(in_auipc_waddr), .in_lui_waddr(in_lui_waddr),
    .in_alu_waddr(in_alu_waddr), .in_load_waddr(in_load_waddr),
    .in_auipc_wen(in_auipc_wen), .in_lui_wen(in_lui_wen),
    .in_alu_wen(in_alu_wen), .in_load_wen(in_load_wen),
    .in_auipc_wdata(in_auipc_wdata), .in_lui_wdata(in_lui_wdata),
    .in_alu_wdata(in_alu_wdata), .in_load_wdata(in_load_wdata),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_retire(out_retire), .out_wb_conflict(out_wb_conflict),
    .out_wb_cnt(out_wb_cnt)
  );

  always #5 in_clk = ~in_clk;

  task automatic clear_wen();
    in_auipc_wen = 1'b0; in_lui_wen = 1'b0; in_alu_wen = 1'b0; in_load_wen = 1'b0;
  endtask

  // Advance one clock, applying the specification's rules to the model.
  task automatic tick();
    logic        wen [4];
    logic [4:0]  adr [4];
    logic [31:0] dat [4];
    int          nw;
    @(posedge in_clk);
    // priority order: load, alu, lui, auipc
    wen = '{in_load_wen, in_alu_wen, in_lui_wen, in_auipc_wen};
    adr = '{in_load_waddr, in_alu_waddr, in_lui_waddr, in_auipc_waddr};
    dat = '{in_load_wdata, in_alu_wdata, in_lui_wdata, in_auipc_wdata};
    if (!in_rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_rs1 = 32'd0; m_rs2 = 32'd0; m_retire = 1'b0; m_conf = 1'b0; m_cnt = 16'd0;
    end else begin
      m_retire = 1'b0;
      if (in_cycle_cnt == 4'd0) begin
        m_rs1 = m_regs[in_rs1];
        m_rs2 = m_regs[in_rs2];
      end
      if (in_cycle_cnt == 4'd2) begin
        nw = 0;
        for (int k = 0; k < 4; k++) nw += int'(wen[k]);
        if (nw > 0) m_retire = 1'b1;
        if (nw > 1) m_conf = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (wen[k]) begin
            if (adr[k] != 5'd0) begin
              m_regs[adr[k]] = dat[k];
              m_cnt = m_cnt + 16'd1;
            end
            break;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    in_rst = 1'b0; in_cycle_cnt = 4'd0; in_rs1 = 5'd31; in_rs2 = 5'd1;
    clear_wen();
    tick(); tick();
    in_rst = 1'b1;
    n_checks++; if (out_rs1_data !== 32'd0) begin n_fail++; $display("FAIL reset_rs1 got %h want 0", out_rs1_data); end
    n_checks++; if (out_rs2_data !== 32'd0) begin n_fail++; $display("FAIL reset_rs2 got %h want 0", out_rs2_data); end
    n_checks++; if (out_retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got %b want 0", out_retire); end
    n_checks++; if (out_wb_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b want 0", out_wb_conflict); end
    n_checks++; if (out_wb_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", out_wb_cnt); end
    tick();
    n_checks++; if (out_rs1_data !== 32'd0) begin n_fail++; $display("FAIL reset_read_x31 got %h want 0", out_rs1_data); end
  endtask

  task automatic test_single_write();
    in_cycle_cnt = 4'd2; in_alu_wen = 1'b1; in_alu_waddr = 5'd5; in_alu_wdata = 32'h12345678;
    tick();
    clear_wen();
    n_checks++; if (out_retire !== 1'b1) begin n_fail++; $display("FAIL single_retire got %b want 1", out_retire); end
    n_checks++; if (out_wb_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %h want 1", out_wb_cnt); end
    in_cycle_cnt = 4'd0; in_rs1 = 5'd5;
    tick();
    n_checks++; if (out_rs1_data !== 32'h12345678) begin n_fail++; $display("FAIL single_read got %h want 12345678", out_rs1_data); end
    n_checks++; if (out_retire !== 1'b0) begin n_fail++; $display("FAIL single_retire_pulse got %b want 0", out_retire); end
  endtask

  task automatic test_x0();
    logic [15:0] cnt_before;
    cnt_before = m_cnt;
    in_cycle_cnt = 4'd2; in_lui_wen = 1'b1; in_lui_waddr = 5'd0; in_lui_wdata = 32'hFFFFFFFF;
    tick();
    clear_wen();
    n_checks++; if (out_retire !== 1'b1) begin n_fail++; $display("FAIL x0_retire got %b want 1", out_retire); end
    n_checks++; if (out_wb_cnt !== cnt_before) begin n_fail++; $display("FAIL x0_cnt got %h want %h", out_wb_cnt, cnt_before); end
    in_cycle_cnt = 4'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    tick();
    n_checks++; if (out_rs1_data !== 32'd0) begin n_fail++; $display("FAIL x0_rs1 got %h want 0", out_rs1_data); end
    n_checks++; if (out_rs2_data !== 32'd0) begin n_fail++; $display("FAIL x0_rs2 got %h want 0", out_rs2_data); end
  endtask

  task automatic test_conflict();
    in_cycle_cnt = 4'd2;
    in_auipc_wen = 1'b1; in_auipc_waddr = 5'd3; in_auipc_wdata = 32'hAAAA0000;
    in_load_wen  = 1'b1; in_load_waddr  = 5'd3; in_load_wdata  = 32'h00005555;
    tick();
    clear_wen();
    n_checks++; if (out_wb_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_set got %b want 1", out_wb_conflict); end
    in_cycle_cnt = 4'd0; in_rs2 = 5'd3;
    tick();
    n_checks++; if (out_rs2_data !== 32'h00005555) begin n_fail++; $display("FAIL conflict_winner got %h want 00005555", out_rs2_data); end
    in_cycle_cnt = 4'd2; in_alu_wen = 1'b1; in_alu_waddr = 5'd4; in_alu_wdata = 32'h0BADF00D;
    tick();
    clear_wen();
    in_cycle_cnt = 4'd1;
    tick();
    n_checks++; if (out_wb_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky got %b want 1", out_wb_conflict); end
  endtask

  task automatic test_out_of_window();
    logic [15:0] cnt_before;
    logic [3:0]  steps [3];
    cnt_before = m_cnt;
    steps = '{4'd0, 4'd1, 4'd3};
    in_rs1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      in_cycle_cnt = steps[k]; in_alu_wen = 1'b1; in_alu_waddr = 5'd7; in_alu_wdata = 32'h1;
      tick();
      n_checks++; if (out_retire !== 1'b0) begin n_fail++; $display("FAIL oow_retire step %0d got %b want 0", steps[k], out_retire); end
    end
    clear_wen();
    in_cycle_cnt = 4'd0;
    tick();
    n_checks++; if (out_rs1_data !== 32'd0) begin n_fail++; $display("FAIL oow_x7 got %h want 0", out_rs1_data); end
    n_checks++; if (out_wb_cnt !== cnt_before) begin n_fail++; $display("FAIL oow_cnt got %h want %h", out_wb_cnt, cnt_before); end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    held = m_rs1;
    in_cycle_cnt = 4'd1; in_rs1 = 5'd3;
    tick(); tick();
    n_checks++; if (out_rs1_data !== held) begin n_fail++; $display("FAIL hold_rs1 got %h want %h", out_rs1_data, held); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_cycle_cnt = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(2 * $urandom_range(0, 1));
      in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_auipc_wen = ($urandom_range(0, 3) == 0); in_lui_wen  = ($urandom_range(0, 3) == 0);
      in_alu_wen   = ($urandom_range(0, 2) == 0); in_load_wen = ($urandom_range(0, 3) == 0);
      in_auipc_waddr = 5'($urandom); in_lui_waddr = 5'($urandom);
      in_alu_waddr   = 5'($urandom); in_load_waddr = 5'($urandom);
      in_auipc_wdata = $urandom; in_lui_wdata = $urandom;
      in_alu_wdata   = $urandom; in_load_wdata = $urandom;
      tick();
      n_checks++; if (out_rs1_data !== m_rs1) begin n_fail++; $display("FAIL rand_rs1 #%0d got %h want %h", n, out_rs1_data, m_rs1); end
      n_checks++; if (out_rs2_data !== m_rs2) begin n_fail++; $display("FAIL rand_rs2 #%0d got %h want %h", n, out_rs2_data, m_rs2); end
      n_checks++; if (out_retire !== m_retire) begin n_fail++; $display("FAIL rand_retire #%0d got %b want %b", n, out_retire, m_retire); end
      n_checks++; if (out_wb_conflict !== m_conf) begin n_fail++; $display("FAIL rand_conflict #%0d got %b want %b", n, out_wb_conflict, m_conf); end
      n_checks++; if (out_wb_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt #%0d got %h want %h", n, out_wb_cnt, m_cnt); end
    end
    clear_wen();
  endtask

  task automatic test_wrap();
    in_rst = 1'b0; clear_wen(); in_cycle_cnt = 4'd1;
    tick();
    in_rst = 1'b1;
    in_cycle_cnt = 4'd2; in_alu_wen = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      in_alu_waddr = 5'($urandom_range(1, 31));
      in_alu_wdata = $urandom;
      tick();
    end
    n_checks++; if (out_wb_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", out_wb_cnt); end
    in_alu_waddr = 5'd1; in_alu_wdata = 32'hC0FFEE01;
    tick();
    clear_wen();
    n_checks++; if (out_wb_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", out_wb_cnt); end
    in_cycle_cnt = 4'd0; in_rs1 = 5'd1;
    tick();
    n_checks++; if (out_rs1_data !== 32'hC0FFEE01) begin n_fail++; $display("FAIL wrap_x1 got %h want c0ffee01", out_rs1_data); end
  endtask

  task automatic test_reset_mid_op();
    in_cycle_cnt = 4'd2; in_load_wen = 1'b1; in_load_waddr = 5'd9; in_load_wdata = 32'hDEADBEEF;
    in_auipc_wen = 1'b1; in_auipc_waddr = 5'd9; in_auipc_wdata = 32'h1;
    in_rst = 1'b0;
    tick();
    clear_wen();
    in_rst = 1'b1;
    n_checks++; if (out_retire !== 1'b0) begin n_fail++; $display("FAIL rstmid_retire got %b want 0", out_retire); end
    n_checks++; if (out_wb_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got %h want 0", out_wb_cnt); end
    n_checks++; if (out_wb_conflict !== 1'b0) begin n_fail++; $display("FAIL rstmid_conflict got %b want 0", out_wb_conflict); end
    n_checks++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_reads got %h/%h want 0/0", out_rs1_data, out_rs2_data); end
    in_cycle_cnt = 4'd0; in_rs1 = 5'd9; in_rs2 = 5'd1;
    tick();
    n_checks++; if (out_rs1_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_x9 got %h want 0", out_rs1_data); end
    n_checks++; if (out_rs2_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_x1 got %h want 0", out_rs2_data); end
  endtask

  initial begin
    in_auipc_waddr = 5'd0; in_lui_waddr = 5'd0; in_alu_waddr = 5'd0; in_load_waddr = 5'd0;
    in_auipc_wdata = 32'd0; in_lui_wdata = 32'd0; in_alu_wdata = 32'd0; in_load_wdata = 32'd0;
    test_reset();
    test_single_write();
    test_x0();
    test_conflict();
    test_out_of_window();
    test_hold();
    test_random();
    test_wrap();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_mcu_wb_regfile.md
SWITCH_MCU_WB_REGFILE -- requirements
Module: switch_mcu_wb_regfile

Interface
REQ-001 SHALL have ports: in_clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: in_rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: in_cycle_cnt  input  4  core multi-cycle step counter.
REQ-004 SHALL have ports: in_rs1, in_rs2  input  5 each  read register indices.
REQ-005 SHALL have ports: in_auipc_waddr/in_lui_waddr/in_alu_waddr/in_load_waddr  input  5 each  write indices from the four execute units.
REQ-006 SHALL have ports: in_auipc_wen/in_lui_wen/in_alu_wen/in_load_wen  input  1 each  write requests.
REQ-007 SHALL have ports: in_auipc_wdata/in_lui_wdata/in_alu_wdata/in_load_wdata  input  32 each  write data.
REQ-008 SHALL have ports: out_rs1_data, out_rs2_data  output  32 each  registered operand data.
REQ-009 SHALL have ports: out_retire  output  1  one-cycle pulse, writeback committed.
REQ-010 SHALL have ports: out_wb_conflict  output  1  sticky multi-source write error flag.
REQ-011 SHALL have ports: out_wb_cnt  output  16  count of architectural register writes.
REQ-012 Parameter: none; register count fixed at 32 x 32 bits.

Function
REQ-013 Storage: x1..x31 as 32-bit flops; x0 has no storage and always reads 0.
REQ-014 Read: when in_cycle_cnt==0, out_rs1_data <= x[in_rs1], out_rs2_data <= x[in_rs2]; otherwise hold.
REQ-015 Writeback window: only when in_cycle_cnt==2; wen inputs at any other count are ignored.
REQ-016 Source select in window, fixed priority: load > alu > lui > auipc; highest-priority asserted wen wins.
REQ-017 Commit: winning waddr != 0 -> x[waddr] <= winning wdata on that edge; waddr==0 -> no register change.
REQ-018 out_retire: 1 for exactly the cycle after a window edge in which any wen was asserted (including waddr==0), else 0.
REQ-019 out_wb_cnt: increments by 1 on each commit with waddr != 0; wraps 16'hFFFF -> 0; x0 writes not counted.
REQ-020 out_wb_conflict: set to 1 at a window edge with two or more wen asserted; stays 1 until reset; the priority winner is still written.
REQ-021 No wen asserted in window: no write, out_retire 0, counters hold.
REQ-022 Read and write never overlap (counts 0 vs 2), so no bypass path; a value written at count 2 is visible at the next count-0 read.
REQ-023 Non-window, non-read cycles: all outputs and registers hold.

Reset
REQ-024 When in_rst==0 at a rising edge: x1..x31, out_rs1_data, out_rs2_data, out_wb_cnt = 0; out_retire, out_wb_conflict = 0.
REQ-025 Reset takes priority over read and window; a reset coinciding with cycle 2 and wen drops the write, no retire pulse, no count.
REQ-026 Between reset edges, registers hold their values indefinitely.

Verification
REQ-027 Single write: count 2, alu_wen=1, waddr=5, wdata=0x12345678; next count 0 rs1=5 -> out_rs1_data=0x12345678, out_retire pulses once, out_wb_cnt=1.
REQ-028 x0: count 2, lui_wen=1, waddr=0, wdata=0xFFFFFFFF; then rs1=0,rs2=0 -> both read 0, out_retire pulses, out_wb_cnt unchanged.
REQ-029 Conflict: count 2, auipc (x3, 0xAAAA0000) and load (x3, 0x00005555) both asserted -> x3=0x00005555, out_wb_conflict=1 and stays 1 across later clean writes until in_rst=0.
REQ-030 Out-of-window: alu_wen=1, waddr=7, wdata=0x1 at counts 0,1,3 -> x7 stays 0, no retire, count unchanged.
REQ-031 Wrap: preload out_wb_cnt to 0xFFFF via 65535 writes, one more write to x1 -> out_wb_cnt=0x0000.
REQ-032 Reset mid-op: in_rst=0 on the count-2 edge with load_wen=1, x9, 0xDEADBEEF -> x9=0, out_retire=0, out_wb_cnt=0, read outputs 0.
